// File: rtl/mist_ioctl_pkg.sv
// Shared types and helpers for the data_io <-> SDRAM ioctl paths.
// Byte lanes follow the download convention: even byte in q[7:0], odd byte in q[15:8].
package mist_ioctl_pkg;

  typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;

  localparam logic [7:0] ERR_BYTE = 8'hFF;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic a0);
    return a0 ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/toggle_handshake_initiator.sv
// Requester side of a toggle req/ack link: request register, post-reset realignment, completion compare, wait timer.
// done is combinational (ack == req); expired is raised once the timer has counted TIMEOUT waiting cycles.
module toggle_handshake_initiator #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic align,
  input  logic start,
  input  logic counting,
  input  logic ack,
  output logic req,
  output logic done,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;

  assign done    = (ack == req);
  assign expired = (timer == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req   <= 1'b0;
      timer <= '0;
    end else if (align) begin
      // Adopt whatever ack level survived reset so a stale ack is never taken as completion.
      req   <= ack;
      timer <= '0;
    end else if (start) begin
      req   <= ~req;
      timer <= '0;
    end else if (counting && !expired) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves data_io upload byte reads from 16-bit SDRAM words through a one-word cache.
// Hit: 1 cycle; miss: 1 + SDRAM latency + 1; reads arriving while a fetch is in flight are dropped and flag err.
module ioctl_upload_reader
  import mist_ioctl_pkg::*;
#(
  parameter int                ADDR_W  = 22,
  parameter logic [ADDR_W-1:0] BASE_W  = '0,
  parameter int                TIMEOUT = 1023
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_din_valid,
  output logic              busy,
  output logic              port_req,
  input  logic              port_ack,
  output logic [ADDR_W-1:0] port_a,
  output logic [1:0]        port_ds,
  output logic              port_we,
  input  logic [15:0]       port_q,
  output logic              err
);

  state_t            state;
  logic [15:0]       cache;
  logic [ADDR_W-1:0] tag;
  logic              cache_vld;
  logic              a0;
  logic              drop;
  logic              upload_q;

  logic [ADDR_W-1:0] w;
  logic              rd_ok, hit, start, done, expired, upload_fall, suppress;
  logic              unused_addr;

  assign port_ds     = 2'b11;
  assign port_we     = 1'b0;
  assign unused_addr = ^ioctl_addr[24:ADDR_W+1];

  assign w           = ioctl_addr[ADDR_W:1] + BASE_W;
  assign rd_ok       = ioctl_rd && ioctl_upload;
  assign hit         = cache_vld && (tag == w);
  assign start       = (state == IDLE) && rd_ok && !hit;
  assign upload_fall = upload_q && !ioctl_upload;
  // A fetch that outlives its upload session still retires, but nobody is listening for the byte.
  assign suppress    = drop || !ioctl_upload;

  toggle_handshake_initiator #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .align    (state == SYNC),
    .start    (start),
    .counting (state == WAIT),
    .ack      (port_ack),
    .req      (port_req),
    .done     (done),
    .expired  (expired)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= SYNC;
      ioctl_din       <= ERR_BYTE;
      ioctl_din_valid <= 1'b0;
      busy            <= 1'b0;
      port_a          <= '0;
      err             <= 1'b0;
      cache           <= '0;
      tag             <= '0;
      cache_vld       <= 1'b0;
      a0              <= 1'b0;
      drop            <= 1'b0;
      upload_q        <= 1'b0;
    end else begin
      upload_q        <= ioctl_upload;
      ioctl_din_valid <= 1'b0;
      if (ioctl_upload && !upload_q) err <= 1'b0;

      case (state)
        SYNC: state <= IDLE;
        IDLE: begin
          if (rd_ok) begin
            if (hit) begin
              ioctl_din       <= byte_sel(cache, ioctl_addr[0]);
              ioctl_din_valid <= 1'b1;
            end else begin
              port_a <= w;
              busy   <= 1'b1;
              a0     <= ioctl_addr[0];
              drop   <= 1'b0;
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (rd_ok) err <= 1'b1;
          if (done) begin
            cache     <= port_q;
            tag       <= port_a;
            cache_vld <= !suppress;
            if (!suppress) begin
              ioctl_din       <= byte_sel(port_q, a0);
              ioctl_din_valid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else if (expired) begin
            if (!suppress) begin
              ioctl_din       <= ERR_BYTE;
              ioctl_din_valid <= 1'b1;
            end
            err       <= 1'b1;
            cache_vld <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (upload_fall) begin
        cache_vld <= 1'b0;
        drop      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench: SDRAM toggle model with 5-cycle ack latency, plus a second instance for base-offset wrap.
module tb_ioctl_upload_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        upload  = 1'b0;
  logic        rd      = 1'b0;
  logic        rd2     = 1'b0;
  logic [24:0] addr    = '0;

  logic [7:0]  din, din2;
  logic        din_valid, din_valid2, busy, busy2, req, req2, we, we2, err, err2;
  logic [21:0] pa, pa2;
  logic [1:0]  ds, ds2;
  logic [15:0] q;
  logic        ack  = 1'b0;
  logic        ack2 = 1'b0;
  logic [15:0] q2   = 16'h0000;

  logic [15:0] mem [0:15];
  assign q = mem[pa[3:0]];

  ioctl_upload_reader #(.ADDR_W(22), .BASE_W(22'h000000), .TIMEOUT(15)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_upload(upload), .ioctl_addr(addr),
    .ioctl_rd(rd), .ioctl_din(din), .ioctl_din_valid(din_valid), .busy(busy),
    .port_req(req), .port_ack(ack), .port_a(pa), .port_ds(ds), .port_we(we),
    .port_q(q), .err(err)
  );

  ioctl_upload_reader #(.ADDR_W(22), .BASE_W(22'h3FFFFF), .TIMEOUT(15)) dut_wrap (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_upload(upload), .ioctl_addr(addr),
    .ioctl_rd(rd2), .ioctl_din(din2), .ioctl_din_valid(din_valid2), .busy(busy2),
    .port_req(req2), .port_ack(ack2), .port_a(pa2), .port_ds(ds2), .port_we(we2),
    .port_q(q2), .err(err2)
  );

  // SDRAM model: a req edge seen while out of reset sets ack to that level 5 cycles later.
  logic req_q  = 1'b0;
  logic target = 1'b0;
  logic ack_en = 1'b1;
  int   cnt    = 0;
  always @(posedge clk) begin
    if (cnt == 1 && ack_en) ack <= target;
    if (cnt != 0) cnt <= cnt - 1;
    if (reset_n && req != req_q) begin
      target <= req;
      cnt    <= 4;
    end
    req_q <= req;
  end

  int         toggles = 0;
  int         pulses  = 0;
  logic       req_prev = 1'b0;
  logic [7:0] last_din = 8'h00;
  always @(posedge clk) begin
    if (reset_n && req != req_prev) toggles <= toggles + 1;
    req_prev <= req;
  end
  always @(negedge clk) begin
    if (din_valid) begin
      pulses   <= pulses + 1;
      last_din <= din;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulses rd for one cycle; lat = negedges until din_valid is seen, 0 if it never comes.
  task automatic do_rd(input logic [24:0] a, output int lat);
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rd = 1'b0;
      if (din_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int t0;
    int p0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'hBEEF; mem[1] = 16'hCAFE; mem[2] = 16'h1234;
    mem[3] = 16'h5678; mem[4] = 16'h9ABC;

    repeat (2) @(negedge clk);
    chk("rst_din", din, 8'hFF);
    chk("rst_valid", din_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_port_a", pa, 22'h0);
    chk("rst_err", err, 1'b0);
    chk("port_ds", ds, 2'b11);
    chk("port_we", we, 1'b0);

    reset_n = 1'b1;
    upload  = 1'b1;
    repeat (3) @(negedge clk);
    chk("sync_align", req, ack);

    // Sequential miss then hit within word 0
    t0 = toggles;
    do_rd(25'd0, lat);
    chk("miss_lat", lat, 7);
    chk("miss_din", din, 8'hEF);
    repeat (2) @(negedge clk);
    chk("miss_toggles", toggles - t0, 1);
    chk("miss_busy", busy, 1'b0);

    t0 = toggles;
    do_rd(25'd1, lat);
    chk("hit_lat", lat, 1);
    chk("hit_din", din, 8'hBE);
    repeat (2) @(negedge clk);
    chk("hit_toggles", toggles - t0, 0);

    // Crossing into word 1
    t0 = toggles;
    do_rd(25'd2, lat);
    chk("wb_lat", lat, 7);
    chk("wb_din", din, 8'hFE);
    chk("wb_port_a", pa, 22'h1);
    repeat (2) @(negedge clk);
    chk("wb_toggles", toggles - t0, 1);

    t0 = toggles;
    do_rd(25'd3, lat);
    chk("wb_hit_lat", lat, 1);
    chk("wb_hit_din", din, 8'hCA);
    repeat (2) @(negedge clk);
    chk("wb_hit_toggles", toggles - t0, 0);

    // Reads outside an upload session are ignored and the session end drops the cache
    upload = 1'b0;
    @(negedge clk);
    t0 = toggles; p0 = pulses;
    addr = 25'd3; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("noup_toggles", toggles - t0, 0);
    chk("noup_pulses", pulses - p0, 0);
    chk("noup_err", err, 1'b0);
    upload = 1'b1;
    @(negedge clk);
    t0 = toggles;
    do_rd(25'd3, lat);
    chk("inval_lat", lat, 7);
    chk("inval_din", din, 8'hCA);
    repeat (2) @(negedge clk);
    chk("inval_toggles", toggles - t0, 1);

    // Base offset wraps the word address
    @(negedge clk);
    addr = 25'd2; rd2 = 1'b1;
    @(negedge clk); rd2 = 1'b0;
    chk("wrap_port_a", pa2, 22'h000000);
    chk("wrap_req", req2, 1'b1);
    chk("wrap_busy", busy2, 1'b1);

    // Timeout with a silent SDRAM
    ack_en = 1'b0;
    do_rd(25'd6, lat);
    chk("to_lat", lat, 17);
    chk("to_din", din, 8'hFF);
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    ack_en = 1'b1;
    t0 = toggles;
    do_rd(25'd6, lat);
    repeat (2) @(negedge clk);
    chk("to_retry_toggles", toggles - t0, 1);

    // A new session clears err
    upload = 1'b0;
    @(negedge clk);
    upload = 1'b1;
    repeat (2) @(negedge clk);
    chk("err_clear", err, 1'b0);

    // Overrun: second read lands two cycles into the fetch
    t0 = toggles; p0 = pulses;
    @(negedge clk); addr = 25'd5; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    @(negedge clk); addr = 25'd0; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    chk("ovr_err", err, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_toggles", toggles - t0, 1);
    chk("ovr_pulses", pulses - p0, 1);
    chk("ovr_din", last_din, 8'h12);
    chk("ovr_busy", busy, 1'b0);

    // Reset while waiting; the model acknowledges during reset
    @(negedge clk); addr = 25'd8; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req", req, 1'b0);
    chk("mid_rst_din", din, 8'hFF);
    chk("mid_rst_err", err, 1'b0);
    repeat (8) @(negedge clk);
    chk("mid_rst_ack", ack, 1'b1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("resync_req", req, 1'b1);
    chk("resync_align", req, ack);
    t0 = toggles;
    do_rd(25'd8, lat);
    chk("post_rst_lat", lat, 7);
    chk("post_rst_din", din, 8'hBC);
    repeat (2) @(negedge clk);
    chk("post_rst_toggles", toggles - t0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
